// File: rtl/ntt_pkg.sv
// Shared constants and helpers for the Z_q (q = 8380417) NTT datapath.
// Includes the Barrett constants and modular halving.
package ntt_pkg;

  localparam int unsigned Q         = 32'd8380417;
  localparam int          QW        = 23;
  localparam int          PROD_W    = 2 * QW;
  localparam int          BARRETT_K = 46;

  typedef logic [QW-1:0] coef_t;

  localparam logic [QW:0] Q_EXT      = (QW+1)'(Q);
  localparam logic [QW:0] BARRETT_MU = (QW+1)'((64'd1 << BARRETT_K) / 64'(Q));

  // x/2 mod Q: an odd x first has Q added, so the sum is even and still below 2Q.
  function automatic coef_t half_mod_q(input coef_t x);
    logic [QW:0] t;
    t = x[0] ? ({1'b0, x} + Q_EXT) : {1'b0, x};
    return t[QW:1];
  endfunction

endpackage

// File: rtl/barrett_reduce_q.sv
// Combinational Barrett reduction of a 46-bit product to [0, Q).
// The quotient estimate undershoots by at most two, hence two correction steps.
module barrett_reduce_q
  import ntt_pkg::*;
(
  input  logic [PROD_W-1:0] x,
  output coef_t             r
);

  localparam int MW = PROD_W + QW + 1;
  localparam int RW = QW + 2;
  localparam logic [RW-1:0] Q_R = RW'(Q);

  logic [MW-1:0]       x_mu;
  logic [QW:0]         q_est;
  logic [PROD_W+1:0]   q_times;
  logic [RW-1:0]       r0;
  logic [RW-1:0]       r1;
  logic [RW-1:0]       r2;

  assign x_mu    = MW'(x) * MW'(BARRETT_MU);
  assign q_est   = (QW+1)'(x_mu >> BARRETT_K);
  assign q_times = (PROD_W+2)'(q_est) * (PROD_W+2)'(Q);

  // The true remainder is below 3Q, so the low RW bits of the difference are exact.
  assign r0 = RW'((PROD_W+2)'(x) - q_times);
  assign r1 = (r0 >= Q_R) ? (r0 - Q_R) : r0;
  assign r2 = (r1 >= Q_R) ? (r1 - Q_R) : r1;
  assign r  = coef_t'(r2);

endmodule

// File: rtl/gs_butterfly_pipe.sv
// Three-stage Gentleman-Sande butterfly: a' = a+b, b' = (a-b)*w, all mod Q,
// with optional halving for the final n^-1 scaling. One shared advance enable.
module gs_butterfly_pipe
  import ntt_pkg::*;
#(
  parameter int DW    = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [DW-1:0]    a_i,
  input  logic [DW-1:0]    b_i,
  input  logic [DW-1:0]    w_i,
  input  logic             half_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [DW-1:0]    a_o,
  output logic [DW-1:0]    b_o,
  output logic [TAG_W-1:0] tag_o
);

  logic advance;

  coef_t       a_c;
  coef_t       b_c;
  logic [QW:0] sum_raw;
  logic [QW:0] diff_raw;
  coef_t       sum_mod;
  coef_t       diff_mod;
  coef_t       s1_sum_next;
  coef_t       s1_diff_next;

  logic             s1_v_reg;
  coef_t            s1_sum_reg;
  coef_t            s1_diff_reg;
  coef_t            s1_w_reg;
  logic [TAG_W-1:0] s1_tag_reg;

  logic              s2_v_reg;
  coef_t             s2_sum_reg;
  logic [PROD_W-1:0] s2_prod_reg;
  logic [PROD_W-1:0] s2_prod_next;
  logic [TAG_W-1:0]  s2_tag_reg;

  logic             s3_v_reg;
  coef_t            s3_sum_reg;
  coef_t            s3_diff_reg;
  coef_t            s3_diff_next;
  logic [TAG_W-1:0] s3_tag_reg;

  // Whole pipeline moves together; a bubble in S3 lets everything shift even under backpressure.
  assign advance    = out_ready_i || !s3_v_reg;
  assign in_ready_o = advance;

  always_comb begin
    a_c          = coef_t'(a_i);
    b_c          = coef_t'(b_i);
    sum_raw      = {1'b0, a_c} + {1'b0, b_c};
    sum_mod      = (sum_raw >= Q_EXT) ? coef_t'(sum_raw - Q_EXT) : coef_t'(sum_raw);
    diff_raw     = (a_c < b_c) ? (({1'b0, a_c} + Q_EXT) - {1'b0, b_c})
                               : ({1'b0, a_c} - {1'b0, b_c});
    diff_mod     = coef_t'(diff_raw);
    s1_sum_next  = half_i ? half_mod_q(sum_mod) : sum_mod;
    s1_diff_next = half_i ? half_mod_q(diff_mod) : diff_mod;
  end

  assign s2_prod_next = PROD_W'(s1_diff_reg) * PROD_W'(s1_w_reg);

  barrett_reduce_q u_reduce (
    .x (s2_prod_reg),
    .r (s3_diff_next)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_v_reg    <= 1'b0;
      s1_sum_reg  <= '0;
      s1_diff_reg <= '0;
      s1_w_reg    <= '0;
      s1_tag_reg  <= '0;
      s2_v_reg    <= 1'b0;
      s2_sum_reg  <= '0;
      s2_prod_reg <= '0;
      s2_tag_reg  <= '0;
      s3_v_reg    <= 1'b0;
      s3_sum_reg  <= '0;
      s3_diff_reg <= '0;
      s3_tag_reg  <= '0;
    end else if (advance) begin
      s1_v_reg    <= in_valid_i;
      s1_sum_reg  <= s1_sum_next;
      s1_diff_reg <= s1_diff_next;
      s1_w_reg    <= coef_t'(w_i);
      s1_tag_reg  <= tag_i;
      s2_v_reg    <= s1_v_reg;
      s2_sum_reg  <= s1_sum_reg;
      s2_prod_reg <= s2_prod_next;
      s2_tag_reg  <= s1_tag_reg;
      s3_v_reg    <= s2_v_reg;
      s3_sum_reg  <= s2_sum_reg;
      s3_diff_reg <= s3_diff_next;
      s3_tag_reg  <= s2_tag_reg;
    end
  end

  assign out_valid_o = s3_v_reg;
  assign a_o         = DW'(s3_sum_reg);
  assign b_o         = DW'(s3_diff_reg);
  assign tag_o       = s3_tag_reg;

endmodule

// File: tb/tb_gs_butterfly_pipe.sv
// Self-checking bench for gs_butterfly_pipe: directed corner cases, backpressure,
// mid-stream reset and a long random stream against a modular-arithmetic model.
module tb_gs_butterfly_pipe;

  localparam longint unsigned Q    = 64'd8380417;
  localparam longint unsigned INV2 = (Q + 64'd1) / 64'd2;
  localparam int DW    = 32;
  localparam int TAG_W = 8;

  typedef struct {
    longint unsigned a;
    longint unsigned b;
    int unsigned     tag;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DW-1:0]    a_in = '0;
  logic [DW-1:0]    b_in = '0;
  logic [DW-1:0]    w_in = '0;
  logic             half = 1'b0;
  logic [TAG_W-1:0] tag_in = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [DW-1:0]    a_out;
  logic [DW-1:0]    b_out;
  logic [TAG_W-1:0] tag_out;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   n_acc = 0;
  int   n_got = 0;

  always #5 clk = ~clk;

  gs_butterfly_pipe #(.DW(DW), .TAG_W(TAG_W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a_in),
    .b_i         (b_in),
    .w_i         (w_in),
    .half_i      (half),
    .tag_i       (tag_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .a_o         (a_out),
    .b_o         (b_out),
    .tag_o       (tag_out)
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, expv);
    end
  endtask

  // Field arithmetic straight from the definition; halving is multiplication by 2^-1 mod Q.
  function automatic exp_t model(input longint unsigned a, input longint unsigned b,
                                 input longint unsigned w, input bit h, input int unsigned tag);
    exp_t e;
    longint unsigned s, d;
    s = (a + b) % Q;
    d = (a + Q - b) % Q;
    if (h) begin
      s = (s * INV2) % Q;
      d = (d * INV2) % Q;
    end
    e.a   = s;
    e.b   = (d * w) % Q;
    e.tag = tag;
    return e;
  endfunction

  task automatic drive(input longint unsigned a, input longint unsigned b,
                       input longint unsigned w, input bit h, input int unsigned tag, input bit v);
    assert (a < Q && b < Q && w < Q) else $error("illegal coefficient driven");
    a_in     = DW'(a);
    b_in     = DW'(b);
    w_in     = DW'(w);
    half     = h;
    tag_in   = TAG_W'(tag);
    in_valid = v;
  endtask

  task automatic drive_rand(input int unsigned tag, input bit v);
    drive($urandom_range(0, int'(Q) - 1), $urandom_range(0, int'(Q) - 1),
          $urandom_range(0, int'(Q) - 1), 1'($urandom_range(0, 1)), tag, v);
  endtask

  // Called just after a falling edge: observes handshakes, scores outputs, advances one cycle.
  task automatic step(output bit accepted);
    exp_t e;
    #1;
    accepted = 1'b0;
    if (out_valid && out_ready) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL spurious_out observed=tag %0d expected=no beat", tag_out);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_a", 64'(a_out), 64'(e.a));
        check("out_b", 64'(b_out), 64'(e.b));
        check("out_tag", 64'(tag_out), 64'(e.tag));
        n_got++;
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(model(64'(a_in), 64'(b_in), 64'(w_in), half, int'(tag_in)));
      accepted = 1'b1;
      n_acc++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic single(input longint unsigned a, input longint unsigned b,
                        input longint unsigned w, input bit h,
                        input longint unsigned ea, input longint unsigned eb, input string name);
    bit acc;
    out_ready = 1'b1;
    drive(a, b, w, h, 8'h5A, 1'b1);
    step(acc);
    check({name, "_accept"}, 64'(acc), 64'd1);
    in_valid = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      #1 check({name, "_lat_early"}, 64'(out_valid), 64'd0);
      step(acc);
    end
    #1;
    check({name, "_lat3_valid"}, 64'(out_valid), 64'd1);
    check({name, "_a"}, 64'(a_out), 64'(ea));
    check({name, "_b"}, 64'(b_out), 64'(eb));
    step(acc);
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    bit acc;
    int k;
    int cyc;
    logic [DW-1:0]    held_a, held_b;
    logic [TAG_W-1:0] held_tag;

    // Reset state
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_a_o", 64'(a_out), 64'd0);
    check("rst_b_o", 64'(b_out), 64'd0);
    check("rst_tag_o", 64'(tag_out), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Directed arithmetic corners
    single(5, 3, 1, 1'b0, 8, 2, "basic");
    single(3, 5, 1, 1'b0, 8, 8380415, "wrap");
    single(1, 0, 1, 1'b1, 4190209, 4190209, "half_odd");
    single(0, 1, 8380416, 1'b0, 1, 1, "qm1_sq");
    single(8380416, 8380416, 2, 1'b0, 8380415, 0, "max_in");

    // Backpressure: six tagged beats against a stalled sink
    out_ready = 1'b0;
    n_acc = 0;
    n_got = 0;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      drive_rand(10 + k, 1'b1);
      step(acc);
      if (acc) k++;
    end
    check("stall_accepts", 64'(n_acc), 64'd3);
    #1;
    check("stall_in_ready", 64'(in_ready), 64'd0);
    check("stall_out_valid", 64'(out_valid), 64'd1);
    check("stall_head_a", 64'(a_out), 64'(exp_q[0].a));
    held_a = a_out;
    held_b = b_out;
    held_tag = tag_out;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("hold_a", 64'(a_out), 64'(held_a));
    check("hold_b", 64'(b_out), 64'(held_b));
    check("hold_tag", 64'(tag_out), 64'(held_tag));
    @(negedge clk);
    out_ready = 1'b1;
    cyc = 0;
    while (n_got < 6 && cyc < 40) begin
      if (k < 6) drive_rand(10 + k, 1'b1);
      else in_valid = 1'b0;
      step(acc);
      if (acc) k++;
      cyc++;
    end
    check("stall_all_out", 64'(n_got), 64'd6);

    // Long random stream with random backpressure
    n_acc = 0;
    n_got = 0;
    cyc = 0;
    k = 0;
    drive_rand(k, 1'b1);
    while (n_acc < 10000 && cyc < 60000) begin
      out_ready = ($urandom_range(0, 99) < 60);
      step(acc);
      if (acc || !in_valid) begin
        k++;
        drive_rand(k & 8'hFF, ($urandom_range(0, 99) < 80));
      end
      cyc++;
    end
    check("rand_accepts", 64'(n_acc), 64'd10000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) step(acc);
    check("rand_all_out", 64'(n_got), 64'(n_acc));
    check("rand_drained", 64'(exp_q.size()), 64'd0);

    // Reset with three beats in flight
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive_rand(200 + c, 1'b1);
      step(acc);
    end
    in_valid = 1'b0;
    #1 check("pre_rst_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    single(100, 7, 3, 1'b0, 107, 279, "post_rst");
    for (int c = 0; c < 4; c++) begin
      #1 check("no_stale", 64'(out_valid), 64'd0);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
